// File: rtl/lcd_hd44780_responder_if.sv
// HD44780 8-bit parallel bus: master is the LCD controller, slave is the panel.
interface lcd_hd44780_responder_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
                  input  lcd_data_out, lcd_data_oe);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
                  output lcd_data_out, lcd_data_oe);
endinterface

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible panel model: 80-byte DDRAM, address counter, busy timing,
// status/data reads and a side read port for display mirroring.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset,
  lcd_hd44780_responder_if.slave bus,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_char,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] cursor_addr,
  output logic       busy_violation
);
  typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

  localparam logic [16:0] BUSY_LD  = 17'(BUSY_CYCLES - 1);
  localparam logic [16:0] CLEAR_LD = 17'(CLEAR_CYCLES - 1);
  localparam logic [6:0]  LAST_IDX = 7'd79;

  logic [7:0]  ddram [80];
  state_t      state;
  logic [16:0] busy_cnt;
  logic [6:0]  fill_idx;
  logic [6:0]  ac;
  logic        e_q;
  logic        incr;
  logic        strobe;
  logic        mem_we;
  logic [6:0]  mem_idx;
  logic [7:0]  mem_wd;
  logic [7:0]  rd_data;

  // Line 1 lives at AC 0x00-0x27, line 2 at AC 0x40-0x67.
  function automatic logic ac_valid(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  function automatic logic [6:0] ac_index(input logic [6:0] a);
    return a[6] ? 7'd40 + {1'b0, a[5:0]} : a;
  endfunction

  // Stepping hops across the unmapped gap between the two lines.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  assign strobe      = e_q & ~bus.lcd_e;
  assign busy        = (state != IDLE);
  assign cursor_addr = ac;
  assign rd_data     = ac_valid(ac) ? ddram[ac_index(ac)] : 8'h20;

  // DDRAM write port: clear-fill has priority; host writes only land when idle.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = fill_idx;
    mem_wd  = 8'h20;
    if (!reset) begin
      if (state == FILL) begin
        mem_we = 1'b1;
      end else if (strobe && !busy && bus.lcd_rs && !bus.lcd_rw && ac_valid(ac)) begin
        mem_we  = 1'b1;
        mem_idx = ac_index(ac);
        mem_wd  = bus.lcd_data_in;
      end
    end
  end

  // DDRAM storage; contents are rebuilt by the fill after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) ddram[mem_idx] <= mem_wd;
  end

  // Side read port for the display mirror.
  always_ff @(posedge clk) begin
    if (reset)                 disp_char <= 8'h20;
    else if (disp_addr < 7'd80) disp_char <= ddram[disp_addr];
    else                       disp_char <= 8'h20;
  end

  // Bus front end, command decode and IDLE/FILL/WAIT busy sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q              <= 1'b0;
      state            <= FILL;
      fill_idx         <= '0;
      busy_cnt         <= CLEAR_LD;
      ac               <= '0;
      incr             <= 1'b1;
      display_on       <= 1'b0;
      cursor_on        <= 1'b0;
      blink_on         <= 1'b0;
      busy_violation   <= 1'b0;
      bus.lcd_data_out <= 8'h00;
      bus.lcd_data_oe  <= 1'b0;
    end else begin
      e_q              <= bus.lcd_e;
      bus.lcd_data_oe  <= bus.lcd_e & bus.lcd_rw;
      bus.lcd_data_out <= (bus.lcd_e & bus.lcd_rw) ?
                          (bus.lcd_rs ? rd_data : {busy, ac}) : 8'h00;

      // FILL cycles are charged against the clear busy time.
      case (state)
        FILL: begin
          busy_cnt <= busy_cnt - 17'd1;
          fill_idx <= fill_idx + 7'd1;
          if (fill_idx == LAST_IDX) state <= (busy_cnt == '0) ? IDLE : WAIT;
        end
        WAIT: begin
          if (busy_cnt == '0) state <= IDLE;
          else                busy_cnt <= busy_cnt - 17'd1;
        end
        default: ;
      endcase

      if (strobe) begin
        if (bus.lcd_rw) begin
          if (bus.lcd_rs) ac <= ac_step(ac, incr);
        end else if (busy) begin
          busy_violation <= 1'b1;
        end else if (bus.lcd_rs) begin
          ac       <= ac_step(ac, incr);
          state    <= WAIT;
          busy_cnt <= BUSY_LD;
        end else begin
          casez (bus.lcd_data_in)
            8'b1???????: begin
              ac <= bus.lcd_data_in[6:0];
              state <= WAIT; busy_cnt <= BUSY_LD;
            end
            8'b01??????, 8'b001?????: begin
              state <= WAIT; busy_cnt <= BUSY_LD;
            end
            8'b0001????: begin
              if (!bus.lcd_data_in[3]) ac <= ac_step(ac, bus.lcd_data_in[2]);
              state <= WAIT; busy_cnt <= BUSY_LD;
            end
            8'b00001???: begin
              display_on <= bus.lcd_data_in[2];
              cursor_on  <= bus.lcd_data_in[1];
              blink_on   <= bus.lcd_data_in[0];
              state <= WAIT; busy_cnt <= BUSY_LD;
            end
            8'b000001??: begin
              incr <= bus.lcd_data_in[1];
              state <= WAIT; busy_cnt <= BUSY_LD;
            end
            8'b0000001?: begin
              ac <= '0;
              state <= WAIT; busy_cnt <= CLEAR_LD;
            end
            8'b00000001: begin
              ac <= '0; incr <= 1'b1; fill_idx <= '0;
              state <= FILL; busy_cnt <= CLEAR_LD;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: linear-index DDRAM model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_lcd_hd44780_responder;
  localparam int BUSY_N  = 20;
  localparam int CLEAR_N = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] disp_addr;
  logic [7:0] disp_char;
  logic       busy, display_on, cursor_on, blink_on, busy_violation;
  logic [6:0] cursor_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_hd44780_responder_if bus();

  lcd_hd44780_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .disp_addr(disp_addr), .disp_char(disp_char), .busy(busy),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .cursor_addr(cursor_addr), .busy_violation(busy_violation)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [80];
  logic [6:0] m_ac;
  logic       m_id, m_eq, m_viol;
  logic [2:0] m_dcb;
  int         m_busy_left, m_fill_left;
  bit         m_valid = 1'b0;

  function automatic bit m_mapped(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  function automatic int m_lin(input logic [6:0] a);
    return (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
  endfunction

  // Mapped addresses move through the 80 linear cells circularly.
  function automatic logic [6:0] m_next(input logic [6:0] a, input logic up);
    int i;
    if (!m_mapped(a)) return up ? a + 7'd1 : a - 7'd1;
    i = m_lin(a);
    i = up ? (i + 1) % 80 : (i + 79) % 80;
    return (i < 40) ? 7'(i) : 7'(i - 40 + 64);
  endfunction

  initial begin : model
    logic       strobe, busy_b, loaded, refill, chk_disp, chk_data, exp_oe;
    logic [7:0] d, exp_disp, exp_data;
    forever begin
      @(posedge clk);
      busy_b   = (m_busy_left > 0);
      chk_disp = (m_fill_left == 0);
      exp_disp = (disp_addr < 7'd80) ? m_mem[disp_addr] : 8'h20;
      exp_oe   = bus.lcd_e & bus.lcd_rw;
      if (bus.lcd_rs) exp_data = m_mapped(m_ac) ? m_mem[m_lin(m_ac)] : 8'h20;
      else            exp_data = {busy_b, m_ac};
      chk_data = exp_oe && !(bus.lcd_rs && m_fill_left > 0);
      loaded = 1'b0;
      refill = 1'b0;
      if (reset) begin
        m_valid = 1'b1;
        m_eq = 1'b0; m_ac = '0; m_id = 1'b1; m_dcb = '0; m_viol = 1'b0;
        m_busy_left = CLEAR_N; m_fill_left = 80;
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        exp_oe = 1'b0; exp_data = 8'h00; chk_data = 1'b1; chk_disp = 1'b0;
      end else begin
        strobe = m_eq & ~bus.lcd_e;
        m_eq   = bus.lcd_e;
        d      = bus.lcd_data_in;
        if (strobe) begin
          if (bus.lcd_rw) begin
            if (bus.lcd_rs) m_ac = m_next(m_ac, m_id);
          end else if (busy_b) begin
            m_viol = 1'b1;
          end else if (bus.lcd_rs) begin
            if (m_mapped(m_ac)) m_mem[m_lin(m_ac)] = d;
            m_ac = m_next(m_ac, m_id);
            m_busy_left = BUSY_N; loaded = 1'b1;
          end else if (d[7]) begin
            m_ac = d[6:0]; m_busy_left = BUSY_N; loaded = 1'b1;
          end else if (d[6] || d[5]) begin
            m_busy_left = BUSY_N; loaded = 1'b1;
          end else if (d[4]) begin
            if (!d[3]) m_ac = m_next(m_ac, d[2]);
            m_busy_left = BUSY_N; loaded = 1'b1;
          end else if (d[3]) begin
            m_dcb = d[2:0]; m_busy_left = BUSY_N; loaded = 1'b1;
          end else if (d[2]) begin
            m_id = d[1]; m_busy_left = BUSY_N; loaded = 1'b1;
          end else if (d[1]) begin
            m_ac = '0; m_busy_left = CLEAR_N; loaded = 1'b1;
          end else if (d[0]) begin
            m_ac = '0; m_id = 1'b1; m_busy_left = CLEAR_N; loaded = 1'b1;
            m_fill_left = 80; refill = 1'b1;
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
          end
        end
        if (!loaded && m_busy_left > 0) m_busy_left--;
        if (!refill && m_fill_left > 0) m_fill_left--;
      end
      #1;
      if (m_valid) begin
        chk("busy", busy, m_busy_left > 0);
        chk("cursor_addr", cursor_addr, m_ac);
        chk("dcb", {display_on, cursor_on, blink_on}, m_dcb);
        chk("busy_violation", busy_violation, m_viol);
        chk("lcd_data_oe", bus.lcd_data_oe, exp_oe);
        if (chk_data) chk("lcd_data_out", bus.lcd_data_out, exp_data);
        if (chk_disp) chk("disp_char", disp_char, exp_disp);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic bus_op(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data_in = d; bus.lcd_e = 1'b1;
    repeat (2) @(negedge clk);
    bus.lcd_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  task automatic wr_instr(input logic [7:0] d);
    bus_op(1'b0, 1'b0, d);
    wait_idle();
  endtask

  task automatic wr_data(input logic [7:0] d);
    bus_op(1'b1, 1'b0, d);
    wait_idle();
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] v, output logic o);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = 1'b1; bus.lcd_e = 1'b1;
    @(negedge clk);
    v = bus.lcd_data_out;
    o = bus.lcd_data_oe;
    @(negedge clk);
    bus.lcd_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_disp(input logic [6:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    disp_addr = a;
    @(negedge clk);
    chk(name, disp_char, exp);
  endtask

  task automatic release_and_count(input string name);
    int n = 0;
    reset = 1'b0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, CLEAR_N);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"}, bus.lcd_data_out, 8'h00);
    chk({tag, "_oe"}, bus.lcd_data_oe, 1'b0);
    chk({tag, "_dcb"}, {display_on, cursor_on, blink_on}, 3'b000);
    chk({tag, "_cursor"}, cursor_addr, 7'h00);
    chk({tag, "_viol"}, busy_violation, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  initial begin
    logic [7:0] v;
    logic       o;
    reset = 1'b1;
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data_in = 8'h00;
    disp_addr = 7'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    release_and_count("por_busy_cycles");
    check_disp(7'd0,   8'h20, "por_idx0");
    check_disp(7'd39,  8'h20, "por_idx39");
    check_disp(7'd40,  8'h20, "por_idx40");
    check_disp(7'd79,  8'h20, "por_idx79");
    check_disp(7'd100, 8'h20, "disp_out_of_range");

    // no-op instruction leaves the panel idle
    bus_op(1'b0, 1'b0, 8'h00);
    chk("noop_not_busy", busy, 1'b0);

    // line-1 end wraps into line 2
    wr_instr(8'h80 | 8'h27);
    wr_data(8'h41);
    wr_data(8'h42);
    check_disp(7'd39, 8'h41, "wrap_idx39");
    check_disp(7'd40, 8'h42, "wrap_idx40");
    chk("wrap_cursor", cursor_addr, 7'h41);

    // decrement mode wraps 0x00 -> 0x67
    wr_instr(8'h04);
    wr_instr(8'h80);
    wr_data(8'h5A);
    check_disp(7'd0, 8'h5A, "dec_idx0");
    chk("dec_cursor", cursor_addr, 7'h67);

    // write while busy is dropped and flagged; status read shows busy + AC
    bus_op(1'b1, 1'b0, 8'h11);
    bus_op(1'b1, 1'b0, 8'h22);
    chk("violation_set", busy_violation, 1'b1);
    bus_read(1'b0, v, o);
    chk("status_oe", o, 1'b1);
    chk("status_value", v, 8'hE6);
    wait_idle();
    check_disp(7'd79, 8'h11, "busy_write_dropped");

    // display control, then data read with AC post-increment
    wr_instr(8'h0F);
    chk("dcb_on", {display_on, cursor_on, blink_on}, 3'b111);
    wr_instr(8'h06);
    wr_instr(8'hC5);
    wr_data(8'h77);
    wr_instr(8'hC5);
    bus_read(1'b1, v, o);
    chk("data_read_oe", o, 1'b1);
    chk("data_read_value", v, 8'h77);
    chk("data_read_cursor", cursor_addr, 7'h46);

    // line-2 end wraps to 0x00
    wr_instr(8'hE7);
    wr_data(8'h33);
    chk("wrap2_cursor", cursor_addr, 7'h00);
    check_disp(7'd79, 8'h33, "wrap2_idx79");

    // unmapped AC: write discarded, read returns space, plain +1
    wr_instr(8'hB0);
    wr_data(8'h44);
    chk("invalid_cursor", cursor_addr, 7'h31);
    wr_instr(8'hB0);
    bus_read(1'b1, v, o);
    chk("invalid_read", v, 8'h20);
    chk("invalid_read_cursor", cursor_addr, 7'h31);

    // cursor shift left/right across the line gap, return home
    wr_instr(8'hC0);
    wr_instr(8'h10);
    chk("shift_left", cursor_addr, 7'h27);
    wr_instr(8'h14);
    chk("shift_right", cursor_addr, 7'h40);
    wr_instr(8'h02);
    chk("home_cursor", cursor_addr, 7'h00);

    // reset in the middle of a clear fill
    bus_op(1'b0, 1'b0, 8'h01);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midfill");
    release_and_count("midfill_busy_cycles");
    check_disp(7'd0,  8'h20, "refill_idx0");
    check_disp(7'd45, 8'h20, "refill_idx45");
    check_disp(7'd79, 8'h20, "refill_idx79");
    chk("refill_viol", busy_violation, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
